// File: rtl/prio_dec2to4_hold_pkg.sv
// Shared types and constants for the priority-index grant holder.
//   state_e             : IDLE / GRANT controller states
//   GNT0..GNT3          : one-hot grant patterns for indices 0..3
//   HOLD_CYCLES_DEFAULT : default number of cycles a grant is held
package prio_dec2to4_hold_pkg;

    localparam int unsigned IDX_W = 2;
    localparam int unsigned GNT_W = 4;
    localparam int unsigned TMR_W = 8;

    localparam int unsigned HOLD_CYCLES_DEFAULT = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    localparam logic [GNT_W-1:0] GNT0 = 4'b0001;
    localparam logic [GNT_W-1:0] GNT1 = 4'b0010;
    localparam logic [GNT_W-1:0] GNT2 = 4'b0100;
    localparam logic [GNT_W-1:0] GNT3 = 4'b1000;

endpackage

// File: rtl/prio_dec2to4_hold_dec2to4.sv
// Combinational 2-to-4 one-hot decoder; inverse of the 4-to-2 priority encoder.
//   idx_i    : encoded index
//   onehot_o : one-hot pattern with bit idx_i set
module dec2to4
    import prio_dec2to4_hold_pkg::*;
(
    input  logic [IDX_W-1:0] idx_i,
    output logic [GNT_W-1:0] onehot_o
);

    always_comb begin
        onehot_o = GNT0;
        unique case (idx_i)
            2'd0: onehot_o = GNT0;
            2'd1: onehot_o = GNT1;
            2'd2: onehot_o = GNT2;
            2'd3: onehot_o = GNT3;
            default: onehot_o = GNT0;
        endcase
    end

endmodule

// File: rtl/prio_dec2to4_hold.sv
// Converts an encoded priority index back into a one-hot grant and holds it
// for HOLD_CYCLES cycles or until released early.
//   clk, rst   : clock, synchronous active-high reset
//   in_valid   : Y/V pair presented;  in_ready : accepted this cycle (comb)
//   Y, V       : encoded index and "any request" flag
//   rel        : early release of the current grant
//   G          : registered one-hot grant;  busy : grant in progress
//   done       : one-cycle pulse when a grant ends
//   grant_cnt  : saturating count of grants issued
module prio_dec2to4_hold
    import prio_dec2to4_hold_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = HOLD_CYCLES_DEFAULT,
    parameter int unsigned CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IDX_W-1:0] Y,
    input  logic             V,
    input  logic             rel,
    output logic [GNT_W-1:0] G,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] grant_cnt
);

    state_e             state_q, state_d;
    logic [GNT_W-1:0]   g_q, g_d;
    logic               done_q, done_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [GNT_W-1:0]   dec_onehot;
    logic               start_grant;
    logic               end_grant;

    dec2to4 u_dec (
        .idx_i    (Y),
        .onehot_o (dec_onehot)
    );

    // A handshake with V=0 is consumed but starts nothing.
    assign start_grant = (state_q == IDLE) && in_valid && V;
    assign end_grant   = (state_q == GRANT) && ((timer_q == '0) || rel);

    // State register and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            g_q     <= '0;
            done_q  <= 1'b0;
            timer_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            g_q     <= g_d;
            done_q  <= done_d;
            timer_q <= timer_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start_grant) state_d = GRANT;
            GRANT:   if (end_grant)   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Grant, timer, counter and done updates.
    always_comb begin
        g_d     = g_q;
        done_d  = 1'b0;
        timer_d = timer_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (start_grant) begin
                    g_d     = dec_onehot;
                    timer_d = TMR_W'(HOLD_CYCLES - 1);
                    if (cnt_q != {CNT_W{1'b1}}) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            GRANT: begin
                if (end_grant) begin
                    g_d    = '0;
                    done_d = 1'b1;
                end else begin
                    timer_d = timer_q - TMR_W'(1);
                end
            end
            default: begin
                g_d = '0;
            end
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q == GRANT);
    assign G         = g_q;
    assign done      = done_q;
    assign grant_cnt = cnt_q;

endmodule

// File: tb/tb_prio_dec2to4_hold.sv
module tb_prio_dec2to4_hold;

    localparam int HOLD  = 4;
    localparam int CNT_W = 8;
    localparam int CMAX  = 255;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       Y;
    logic             V;
    logic             rel;
    logic [3:0]       G;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] grant_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model: a grant is "index m_idx, been high for m_held cycles".
    bit m_active = 1'b0;
    int m_idx    = 0;
    int m_held   = 0;
    int m_cnt    = 0;
    bit m_done   = 1'b0;
    int done_pulses = 0;

    prio_dec2to4_hold #(.HOLD_CYCLES(HOLD), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Y         (Y),
        .V         (V),
        .rel       (rel),
        .G         (G),
        .busy      (busy),
        .done      (done),
        .grant_cnt (grant_cnt)
    );

    always #5 clk = ~clk;

    task automatic model_edge(input bit r, input bit iv, input bit [1:0] y,
                              input bit v, input bit rl);
        bit was;
        if (r) begin
            m_active = 1'b0;
            m_held   = 0;
            m_cnt    = 0;
            m_done   = 1'b0;
        end else begin
            was    = m_active;
            m_done = 1'b0;
            if (was) begin
                if (m_held >= HOLD || rl) begin
                    m_active = 1'b0;
                    m_done   = 1'b1;
                end else begin
                    m_held++;
                end
            end else if (iv && v) begin
                m_active = 1'b1;
                m_idx    = int'(y);
                m_held   = 1;
                if (m_cnt < CMAX) m_cnt++;
            end
        end
    endtask

    task automatic check_all();
        logic [3:0] exp_g;
        exp_g = m_active ? 4'(1 << m_idx) : 4'b0000;
        checks++;
        assert (G === exp_g) else begin
            errors++;
            $error("FAIL G observed=%b expected=%b t=%0t", G, exp_g, $time);
        end
        checks++;
        assert (busy === m_active) else begin
            errors++;
            $error("FAIL busy observed=%b expected=%b t=%0t", busy, m_active, $time);
        end
        checks++;
        assert (done === m_done) else begin
            errors++;
            $error("FAIL done observed=%b expected=%b t=%0t", done, m_done, $time);
        end
        checks++;
        assert (in_ready === !m_active) else begin
            errors++;
            $error("FAIL in_ready observed=%b expected=%b t=%0t", in_ready, !m_active, $time);
        end
        checks++;
        assert (grant_cnt === CNT_W'(m_cnt)) else begin
            errors++;
            $error("FAIL grant_cnt observed=%0d expected=%0d t=%0t", grant_cnt, m_cnt, $time);
        end
        checks++;
        assert ($countones(G) <= 1) else begin
            errors++;
            $error("FAIL onehot observed=%b expected=at most one bit t=%0t", G, $time);
        end
        if (done === 1'b1) done_pulses++;
    endtask

    // Drive inputs, take one clock edge, advance the model, check after the edge.
    task automatic step(input bit r, input bit iv, input bit [1:0] y,
                        input bit v, input bit rl);
        rst = r; in_valid = iv; Y = y; V = v; rel = rl;
        @(posedge clk);
        model_edge(r, iv, y, v, rl);
        #1;
        check_all();
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 2'($urandom), 1'($urandom), 1'($urandom));
    endtask

    initial begin
        int pulses0;
        rst = 1'b1; in_valid = 1'b0; Y = 2'b00; V = 1'b0; rel = 1'b0;

        // Reset then idle
        step(1, 0, 0, 0, 0);
        step(1, 1, 2'b11, 1, 1);
        idle_steps(2);

        // Basic hold, Y=10
        pulses0 = done_pulses;
        step(0, 1, 2'b10, 1, 0);
        for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 0);
        checks++;
        assert (done_pulses - pulses0 == 1) else begin
            errors++;
            $error("FAIL basic_done_count observed=%0d expected=1", done_pulses - pulses0);
        end

        // No-request transfer
        step(0, 1, 2'b00, 0, 0);
        step(0, 1, 2'b01, 0, 1);
        idle_steps(2);

        // Early release on 2nd grant cycle, then on 4th (collides with expiry)
        step(0, 1, 2'b11, 1, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0);
        pulses0 = done_pulses;
        step(0, 1, 2'b11, 1, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        checks++;
        assert (done_pulses - pulses0 == 1) else begin
            errors++;
            $error("FAIL collision_done_count observed=%0d expected=1", done_pulses - pulses0);
        end

        // Back-to-back sweep; Y randomised while granting
        step(1, 0, 0, 0, 0);
        for (int k = 0; k < 20; k++)
            step(0, 1, (k % 5 == 0) ? 2'(k / 5) : 2'($urandom), 1, 0);
        step(0, 0, 0, 0, 0);
        checks++;
        assert (grant_cnt === 8'd4) else begin
            errors++;
            $error("FAIL sweep_cnt observed=%0d expected=4", grant_cnt);
        end

        // Reset mid-grant
        step(0, 1, 2'b01, 1, 0);
        step(0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);

        // Saturation: 260 grants with early release
        for (int n = 0; n < 260; n++) begin
            step(0, 1, 2'($urandom), 1, 0);
            step(0, 0, 2'($urandom), 1'($urandom), 1);
            step(0, 0, 0, 0, 0);
        end
        checks++;
        assert (grant_cnt === 8'd255) else begin
            errors++;
            $error("FAIL saturate observed=%0d expected=255", grant_cnt);
        end

        // Random traffic
        for (int n = 0; n < 3000; n++)
            step(($urandom_range(0, 199) == 0), 1'($urandom), 2'($urandom),
                 1'($urandom), ($urandom_range(0, 5) == 0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
